// File: rtl/pwm_meter.sv
// Measures the period and high time of a PWM input in clk cycles and flags a line stuck at 0% or 100% duty.
// Each completed period gets a one-cycle valid strobe. Entering the stuck state gives one more strobe, with zero values.
module pwm_meter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         stuck,
    output logic         stuck_level
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        STUCK
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t       state_q, state_d;
    logic         s1_q, s2_q, s3_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_q, high_d;
    logic         valid_q, valid_d;
    logic         stuck_q, stuck_d;
    logic         level_q, level_d;

    logic rise, fall, cnt_sat;

    // The three-flop input chain adds the same delay to every edge, so it cancels out of the measured counts.
    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign cnt_sat = (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d  = state_q;
        hi_d     = hi_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        level_d  = level_q;
        cnt_d    = rise ? W'(1) : (cnt_sat ? cnt_q : cnt_q + W'(1));

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                    hi_d    = '0;
                end
            end
            ARMED: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
                    hi_d     = '0;
                end else if (cnt_sat) begin
                    state_d  = STUCK;
                    stuck_d  = 1'b1;
                    level_d  = s2_q;
                    period_d = '0;
                    high_d   = '0;
                    valid_d  = 1'b1;
                end else if (fall) begin
                    hi_d = cnt_q;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d = ARMED;
                    hi_d    = '0;
                    stuck_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments, so every flop samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= pwm_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            level_q  <= level_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = level_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Testbench for pwm_meter with W=8. A rise-index reference model is checked against the outputs every cycle.
// Directed waveform tables, stuck and reset sequences, and random segments supply the stimulus.
module tb_pwm_meter;

    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         pwm_in;
    logic [W-1:0] period, high_time;
    logic         valid, stuck, stuck_level;

    pwm_meter #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .valid      (valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the samples seen at each clock edge are numbered. A period is the difference between
    // the indices of two consecutive rises. The high time is the index of the fall minus the index of the rise.
    typedef enum int {M_IDLE, M_ARMED, M_STUCK} mmode_t;
    typedef struct packed {
        logic         v;
        logic         s;
        logic         sl;
        logic [W-1:0] p;
        logic [W-1:0] h;
    } obs_t;

    mmode_t m_mode;
    int     m_n = 0, m_last_rise, m_fall_at;
    bit     m_prev, m_valid, m_stuck, m_level;
    int     m_per, m_hi;
    obs_t   d1, d2, exp_obs;

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_prev    = 1'b0;
        m_fall_at = -1;
        m_last_rise = 0;
        m_valid = 0; m_stuck = 0; m_level = 0; m_per = 0; m_hi = 0;
        d1 = '0; d2 = '0; exp_obs = '0;
    endtask

    task automatic model_step(input bit x);
        obs_t cur;
        m_n++;
        m_valid = 1'b0;
        if (x && !m_prev) begin
            if (m_mode == M_ARMED) begin
                m_valid = 1'b1;
                m_per   = m_n - m_last_rise;
                m_hi    = (m_fall_at > m_last_rise) ? m_fall_at - m_last_rise : 0;
            end
            m_mode      = M_ARMED;
            m_stuck     = 1'b0;
            m_last_rise = m_n;
        end else if (m_mode == M_ARMED) begin
            if (!x && m_prev) m_fall_at = m_n;
            if (m_n - m_last_rise == MAXC) begin
                m_mode  = M_STUCK;
                m_stuck = 1'b1;
                m_level = x;
                m_per   = 0;
                m_hi    = 0;
                m_valid = 1'b1;
            end
        end
        m_prev = x;
        cur = {m_valid, m_stuck, m_level, W'(m_per), W'(m_hi)};
        // The registered outputs that follow an edge reflect the sample taken two edges earlier.
        exp_obs = d2;
        d2 = d1;
        d1 = cur;
    endtask

    int n_valid, consec;
    bit prev_valid, saw_zero;
    logic [W-1:0] last_p, last_h;

    // One clock: drive the input, let the model see the edge, then compare on the falling edge.
    task automatic cycle(input bit x);
        pwm_in = x;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(x);
        @(negedge clk);
        check("cycle", {valid, stuck, stuck_level, period, high_time}, exp_obs);
        if (valid) begin
            n_valid++;
            last_p = period;
            last_h = high_time;
            if (period == 0 && high_time == 0) saw_zero = 1'b1;
        end
        if (valid && prev_valid) consec++;
        prev_valid = valid;
    endtask

    task automatic run_pwm(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < per; i++)
                cycle(i < hi);
    endtask

    task automatic hold(input bit lvl, input int n);
        for (int i = 0; i < n; i++) cycle(lvl);
    endtask

    typedef struct {
        int per;
        int hi;
        int reps;
        int exp_valids;
        int exp_per;
        int exp_hi;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // The first valid of each entry reports the previous entry's last period.
        tbl = '{'{64, 16, 4, 3, 64, 16},
                '{64, 48, 3, 3, 64, 48},
                '{20,  5, 4, 4, 20,  5},
                '{ 4,  2, 8, 8,  4,  2},
                '{255, 200, 3, 3, 255, 200},
                '{ 7,  3, 5, 5,  7,  3}};

        reset = 1'b1;
        pwm_in = 1'b0;
        n_valid = 0; consec = 0; prev_valid = 0; saw_zero = 0;
        last_p = '0; last_h = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", {valid, stuck, stuck_level, period, high_time}, '0);
        cycle(1'b0);
        reset = 1'b0;
        cycle(1'b0);

        for (int i = 0; i < 6; i++) begin
            n_valid = 0;
            run_pwm(tbl[i].per, tbl[i].hi, tbl[i].reps);
            check($sformatf("tbl%0d_valids", i), n_valid, tbl[i].exp_valids);
            check($sformatf("tbl%0d_period", i), last_p, tbl[i].exp_per);
            check($sformatf("tbl%0d_high", i), last_h, tbl[i].exp_hi);
            check($sformatf("tbl%0d_stuck", i), stuck, 1'b0);
        end
        check("no_consecutive_valid", consec, 0);

        // Line held low after a rise: the stuck flag rises with a zero-valued strobe.
        run_pwm(20, 5, 1);
        saw_zero = 1'b0;
        hold(1'b0, 270);
        check("stuck_low_flag", stuck, 1'b1);
        check("stuck_low_level", stuck_level, 1'b0);
        check("stuck_low_zero_valid", saw_zero, 1'b1);
        check("stuck_low_period", {period, high_time}, '0);

        // Resuming from stuck: the first rise only re-arms, so three rises give two reports.
        n_valid = 0;
        run_pwm(20, 5, 3);
        check("resume_valids", n_valid, 2);
        check("resume_period", last_p, 20);
        check("resume_high", last_h, 5);
        check("resume_stuck", stuck, 1'b0);

        // Line held high.
        saw_zero = 1'b0;
        hold(1'b1, 270);
        check("stuck_high_flag", stuck, 1'b1);
        check("stuck_high_level", stuck_level, 1'b1);
        check("stuck_high_zero_valid", saw_zero, 1'b1);

        // Reset asserted between clock edges in the middle of a period.
        run_pwm(20, 5, 2);
        pwm_in = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", {valid, stuck, stuck_level, period, high_time}, '0);
        @(negedge clk);
        model_reset();
        prev_valid = 1'b0;
        cycle(1'b1);
        cycle(1'b0);
        reset = 1'b0;
        n_valid = 0;
        run_pwm(20, 5, 3);
        check("post_reset_valids", n_valid, 2);
        check("post_reset_period", last_p, 20);
        check("post_reset_high", last_h, 5);

        // Random segments: PWM bursts mixed with long constant stretches.
        for (int s = 0; s < 30; s++) begin
            int r, per, hi;
            r = $urandom_range(0, 5);
            if (r == 0) begin
                hold(1'($urandom_range(0, 1)), $urandom_range(200, 300));
            end else begin
                per = $urandom_range(4, 60);
                hi  = $urandom_range(2, per - 2);
                run_pwm(per, hi, $urandom_range(1, 3));
            end
        end
        check("random_no_consecutive_valid", consec, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
